binary_to_bcd_seq: RTL and testbench

- Sequential 16-bit binary to 4-digit BCD converter using shift-and-add-3 (double dabble).
- Built from two sub-blocks: `controller`, an FSM issuing loadBin and shiftCount, and `dataPath`, which holds the binary and BCD shift registers, the add-3 logic, the shift counter and the overflow flags.
- Used as a standalone conversion peripheral: pulse start, wait for done, read BCD.

---
 rtl/binary_to_bcd_seq_if.sv | 28 ++
 rtl/binary_to_bcd_seq.sv | 150 +++++++++++++++
 tb/tb_binary_to_bcd_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/binary_to_bcd_seq_if.sv
// Conversion request/result bundle for binary_to_bcd_seq.
// The master drives the operand and start; the slave returns the BCD result and status.
interface binary_to_bcd_seq_if;
    logic [15:0] Bin;
    logic        start;
    logic [15:0] BCD;
    logic        done;
    logic        co;
    logic        so;

    modport master (
        output Bin,
        output start,
        input  BCD,
        input  done,
        input  co,
        input  so
    );

    modport slave (
        input  Bin,
        input  start,
        output BCD,
        output done,
        output co,
        output so
    );
endinterface

// File: rtl/binary_to_bcd_seq.sv
// Sequential 16-bit binary to 4-digit BCD converter (shift-and-add-3).
// The controller FSM sequences load/shift; the dataPath holds the shift registers and flags.

module controller (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic cnt_last,
    output logic loadBin,
    output logic shiftCount,
    output logic done
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        loadBin    = 1'b0;
        shiftCount = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                loadBin = 1'b1;
                if (!start) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                shiftCount = 1'b1;
                // cnt_last marks the 16th shift happening on this edge
                if (cnt_last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end
endmodule

module dataPath (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Bin,
    input  logic        loadBin,
    input  logic        shiftCount,
    output logic [15:0] BCD,
    output logic        co,
    output logic        so,
    output logic        cnt_last
);
    logic [15:0] binreg;
    logic [15:0] bcd_reg;
    logic [15:0] bcd_corr;
    logic [3:0]  cnt;
    logic        co_reg;
    logic        so_reg;

    // Per-digit add-3; digits are independent, so no carry crosses a nibble
    always_comb begin
        bcd_corr = bcd_reg;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd_reg[4*i +: 4] >= 4'd5) begin
                bcd_corr[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            binreg  <= '0;
            bcd_reg <= '0;
            cnt     <= '0;
            co_reg  <= 1'b0;
            so_reg  <= 1'b0;
        end else if (loadBin) begin
            binreg  <= Bin;
            bcd_reg <= '0;
            cnt     <= '0;
            co_reg  <= 1'b0;
            so_reg  <= 1'b0;
        end else if (shiftCount) begin
            {bcd_reg, binreg} <= {bcd_corr[14:0], binreg, 1'b0};
            so_reg            <= bcd_corr[15];
            co_reg            <= co_reg | bcd_corr[15];
            cnt               <= cnt + 4'd1;
        end
    end

    assign cnt_last = (cnt == 4'd15);
    assign BCD      = bcd_reg;
    assign co       = co_reg;
    assign so       = so_reg;
endmodule

module binary_to_bcd_seq (
    input  logic                 clk,
    input  logic                 rst,
    binary_to_bcd_seq_if.slave   bus
);
    logic loadBin;
    logic shiftCount;
    logic cnt_last;

    controller u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .start      (bus.start),
        .cnt_last   (cnt_last),
        .loadBin    (loadBin),
        .shiftCount (shiftCount),
        .done       (bus.done)
    );

    dataPath u_dp (
        .clk        (clk),
        .rst        (rst),
        .Bin        (bus.Bin),
        .loadBin    (loadBin),
        .shiftCount (shiftCount),
        .BCD        (bus.BCD),
        .co         (bus.co),
        .so         (bus.so),
        .cnt_last   (cnt_last)
    );
endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Scoreboard bench for binary_to_bcd_seq: expected {so, co, BCD} queued at stimulus,
// compared when done pulses.
module tb_binary_to_bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    binary_to_bcd_seq_if bus();

    binary_to_bcd_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    logic [17:0] sb[$];
    logic [17:0] exp_e;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits of Bin mod 10000; co if Bin > 9999;
    // so is the LSB of the ten-thousands digit (last bit pushed out of BCD[15]).
    function automatic logic [17:0] model(input logic [15:0] b);
        int unsigned v;
        int unsigned lo;
        int unsigned hi;
        logic [15:0] d;
        v  = 32'(b);
        lo = v % 10000;
        hi = v / 10000;
        d  = {4'(lo / 1000), 4'((lo / 100) % 10), 4'((lo / 10) % 10), 4'(lo % 10)};
        return {1'(hi & 1), 1'(hi != 0), d};
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            done_cnt++;
            check_val("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp_e = sb.pop_front();
                check_val("bcd", 32'(bus.BCD), 32'(exp_e[15:0]));
                check_val("co",  32'(bus.co),  32'(exp_e[16]));
                check_val("so",  32'(bus.so),  32'(exp_e[17]));
            end
        end
    end

    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic convert(input logic [15:0] b, input int hold);
        int lat;
        @(posedge clk); #1;
        bus.Bin   = b;
        bus.start = 1'b1;
        sb.push_back(model(b));
        repeat (hold) @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat);
        check_val("latency", 32'(lat), 32'd17);
        @(posedge clk); #1;
        check_val("done_one_cycle", 32'(bus.done), 32'd0);
    endtask

    initial begin
        int lat;
        int saved;
        bus.Bin   = '0;
        bus.start = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_bcd",  32'(bus.BCD),  32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        check_val("rst_co",   32'(bus.co),   32'd0);
        check_val("rst_so",   32'(bus.so),   32'd0);
        rst = 1'b0;

        convert(16'h1BE6, 3);
        repeat (3) @(posedge clk);
        #1 check_val("hold_bcd", 32'(bus.BCD), 32'h7142);
        convert(16'd321, 1);
        convert(16'd9999, 1);
        convert(16'd0, 1);
        convert(16'd65535, 1);
        convert(16'd10000, 1);
        for (int i = 0; i < 4; i++) begin
            convert(16'($urandom_range(0, 65535)), 1 + int'($urandom_range(0, 2)));
        end

        // start and Bin wiggle during SHIFT must not disturb the conversion
        saved = done_cnt;
        @(posedge clk); #1;
        bus.Bin   = 16'd4321;
        bus.start = 1'b1;
        sb.push_back(model(16'd4321));
        @(posedge clk); #1 bus.start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                break;
            end
            bus.start = (k < 12) ? 1'(k & 1) : 1'b0;
            bus.Bin   = 16'($urandom);
        end
        bus.start = 1'b0;
        check_val("toggle_latency", 32'(lat), 32'd17);
        repeat (5) @(posedge clk);
        #1 check_val("toggle_done_count", 32'(done_cnt), 32'(saved + 1));

        // start held high through DONE launches a second conversion
        @(posedge clk); #1;
        bus.Bin   = 16'd1234;
        bus.start = 1'b1;
        sb.push_back(model(16'd1234));
        @(posedge clk); #1 bus.start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (k >= 10) bus.start = 1'b1;
        end
        check_val("b2b_first_latency", 32'(lat), 32'd17);
        bus.Bin = 16'd5678;
        sb.push_back(model(16'd5678));
        repeat (4) @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat);
        check_val("b2b_second_latency", 32'(lat), 32'd17);

        // reset in the middle of SHIFT discards the partial result
        @(posedge clk); #1;
        bus.Bin   = 16'd65535;
        bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_val("midrst_bcd",  32'(bus.BCD),  32'd0);
        check_val("midrst_co",   32'(bus.co),   32'd0);
        check_val("midrst_so",   32'(bus.so),   32'd0);
        check_val("midrst_done", 32'(bus.done), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        saved = done_cnt;
        repeat (25) @(posedge clk);
        #1 check_val("midrst_no_done", 32'(done_cnt), 32'(saved));
        convert(16'd8765, 2);

        repeat (2) @(posedge clk);
        #1 check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
